// File: rtl/bool_eval_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// bool_eval_sweep_ctrl_if
// Groups the sweep controller's control/result signals.
//   start        request a sweep (sampled only while the controller is idle)
//   y_i          output of the switch-level evaluator (4-state, may float)
//   vec_o        {a,b,c,d} drive to the evaluator
//   busy         sweep in progress
//   done         one-cycle completion pulse
//   truth_table  captured y per vector
//   mismatch_cnt vectors that differed from the expected table (0..16)
//   pass         1 iff no mismatches and no X/Z sample
//   xz_seen      sticky, some sample was neither 0 nor 1
// Modports: slave = sweep controller, master = test/control side.
// ---------------------------------------------------------------------------
interface bool_eval_sweep_ctrl_if;
    logic        start;
    logic        y_i;
    logic [3:0]  vec_o;
    logic        busy;
    logic        done;
    logic [15:0] truth_table;
    logic [4:0]  mismatch_cnt;
    logic        pass;
    logic        xz_seen;

    modport slave (
        input  start, y_i,
        output vec_o, busy, done, truth_table, mismatch_cnt, pass, xz_seen
    );

    modport master (
        output start, y_i,
        input  vec_o, busy, done, truth_table, mismatch_cnt, pass, xz_seen
    );
endinterface

// File: rtl/bool_eval_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// bool_eval_sweep_ctrl
// Walks the switch-level evaluator (y = a.b + c.d) through all 16 input
// vectors, holds each for SETTLE_CYCLES clocks, samples y, builds a truth
// table and compares it with EXPECTED_TT.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    bool_eval_sweep_ctrl_if.slave (start, y_i in; vec_o, busy, done,
//          truth_table, mismatch_cnt, pass, xz_seen out)
// Optional feature macro: SWEEP_ABORT_ON_FAIL_EN -- when defined the first
// mismatching (or X/Z) sample ends the sweep.
// ---------------------------------------------------------------------------
module bool_eval_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [15:0] EXPECTED_TT   = 16'hF888
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bool_eval_sweep_ctrl_if.slave bus
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_settle_range
        $error("SETTLE_CYCLES must be in 1..15");
    end

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    logic [1:0]  state_q;
    logic [3:0]  cnt_q;
    logic [3:0]  vec_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] tt_q;
    logic [4:0]  mc_q;
    logic        pass_q;
    logic        xz_q;

    logic        sample_xz;
    logic        sample_mis;

    // Case equality so a floating/contended y_i is caught rather than
    // silently compared as 0 or 1.
    always_comb begin
        sample_xz  = (bus.y_i !== 1'b0) && (bus.y_i !== 1'b1);
        sample_mis = sample_xz || (bus.y_i !== EXPECTED_TT[vec_q]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tt_q    <= '0;
            mc_q    <= '0;
            pass_q  <= 1'b0;
            xz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    vec_q <= '0;
                    if (bus.start) begin
                        tt_q    <= '0;
                        mc_q    <= '0;
                        xz_q    <= 1'b0;
                        pass_q  <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == SETTLE_LAST) begin
                        state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    tt_q[vec_q] <= (bus.y_i === 1'b1);
                    if (sample_xz) begin
                        xz_q <= 1'b1;
                    end
                    if (sample_mis && mc_q != 5'd16) begin
                        mc_q <= mc_q + 5'd1;
                    end
`ifdef SWEEP_ABORT_ON_FAIL_EN
                    if (sample_mis || vec_q == 4'd15) begin
`else
                    if (vec_q == 4'd15) begin
`endif
                        state_q <= DONE;
                    end else begin
                        vec_q   <= vec_q + 4'd1;
                        cnt_q   <= '0;
                        state_q <= SETTLE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    pass_q  <= (mc_q == 5'd0) && !xz_q;
                    vec_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.vec_o        = vec_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.truth_table  = tt_q;
    assign bus.mismatch_cnt = mc_q;
    assign bus.pass         = pass_q;
    assign bus.xz_seen      = xz_q;

endmodule

// File: tb/tb_bool_eval_sweep_ctrl.sv
module tb_bool_eval_sweep_ctrl;

    localparam int SETTLE = 2;
    localparam logic [15:0] EXP_TT = 16'hF888;

    logic clk;
    logic rst_n;
    logic [15:0] yv;     // y value the bench evaluator returns for each vector

    int vectors;
    int miscompares;

    bool_eval_sweep_ctrl_if bus();

    bool_eval_sweep_ctrl #(
        .SETTLE_CYCLES(SETTLE),
        .EXPECTED_TT  (EXP_TT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb bus.y_i = yv[bus.vec_o];

    // Reference: apply the sweep rules to the per-vector y values.
    function automatic void model(input logic [15:0] y, output logic [15:0] tt,
                                  output int mc, output bit xz, output bit ps,
                                  output int lat);
        int swept;
        bit stop;
        tt = '0; mc = 0; xz = 1'b0; swept = 0; stop = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!stop) begin
                bit is_xz;
                bit mis;
                is_xz = (y[i] !== 1'b0) && (y[i] !== 1'b1);
                mis   = is_xz || (y[i] !== EXP_TT[i]);
                tt[i] = (y[i] === 1'b1);
                if (is_xz) xz = 1'b1;
                if (mis) mc++;
                swept++;
`ifdef SWEEP_ABORT_ON_FAIL_EN
                if (mis) stop = 1'b1;
`endif
            end
        end
        ps  = (mc == 0) && !xz;
        lat = swept * (SETTLE + 1) + 1;
    endfunction

    function automatic logic [15:0] golden();
        logic [15:0] g;
        for (int i = 0; i < 16; i++) begin
            g[i] = (i[3] & i[2]) | (i[1] & i[0]);
        end
        return g;
    endfunction

    // Launch one sweep and measure cycles from the accepting edge to done.
    task automatic do_sweep(input bit noise, output int lat, output bit busy1);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        busy1 = bus.busy;
        lat = 0;
        while (lat < 2000) begin
            @(posedge clk); #1;
            lat++;
            if (bus.done) break;
            if (noise) bus.start = 1'($urandom % 2);
        end
        bus.start = 1'b0;
        if (!bus.done) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        yv = golden();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({bus.vec_o, bus.busy, bus.done, bus.truth_table, bus.mismatch_cnt, bus.pass, bus.xz_seen} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got vec=%h busy=%b done=%b tt=%h mc=%0d pass=%b xz=%b, want all 0",
                     bus.vec_o, bus.busy, bus.done, bus.truth_table, bus.mismatch_cnt, bus.pass, bus.xz_seen);
        end
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.vec_o !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_idle: busy=%b vec=%h, want 0/0", bus.busy, bus.vec_o);
        end
    endtask

    // Shared by the fixed-pattern scenarios; each comparison is inline.
    task automatic test_pattern(input string name, input logic [15:0] y, input bit noise);
        logic [15:0] tt_e;
        int mc_e, lat_e, lat;
        bit xz_e, ps_e, busy1;
        yv = y;
        model(y, tt_e, mc_e, xz_e, ps_e, lat_e);
        do_sweep(noise, lat, busy1);
        vectors++;
        if (busy1 !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_busy: got %b want 1", name, busy1);
        end
        vectors++;
        if (lat != lat_e) begin
            miscompares++;
            $display("FAIL %s_latency: got %0d want %0d", name, lat, lat_e);
        end
        vectors++;
        if (bus.truth_table !== tt_e) begin
            miscompares++;
            $display("FAIL %s_tt: got %h want %h", name, bus.truth_table, tt_e);
        end
        vectors++;
        if (bus.mismatch_cnt !== 5'(mc_e)) begin
            miscompares++;
            $display("FAIL %s_mc: got %0d want %0d", name, bus.mismatch_cnt, mc_e);
        end
        vectors++;
        if (bus.pass !== ps_e || bus.xz_seen !== xz_e || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_flags: got pass=%b xz=%b busy=%b want %b %b 0",
                     name, bus.pass, bus.xz_seen, bus.busy, ps_e, xz_e);
        end
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1;
        vectors++;
        if (bus.truth_table !== tt_e || bus.mismatch_cnt !== 5'(mc_e) || bus.pass !== ps_e || bus.vec_o !== 4'd0) begin
            miscompares++;
            $display("FAIL %s_hold: got tt=%h mc=%0d pass=%b vec=%h want %h %0d %b 0",
                     name, bus.truth_table, bus.mismatch_cnt, bus.pass, bus.vec_o, tt_e, mc_e, ps_e);
        end
    endtask

    task automatic test_nominal();
        test_pattern("nominal", golden(), 1'b0);
    endtask

    task automatic test_stuck0();
        test_pattern("stuck0", 16'h0000, 1'b0);
    endtask

    task automatic test_z_at_12();
        logic [15:0] y;
        y = golden();
        y[12] = 1'bz;
        test_pattern("z12", y, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            logic [15:0] mask;
            mask = 16'($urandom) & 16'($urandom);
            if (n == 0) mask = 16'hFFFF;
            test_pattern("random", golden() ^ mask, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        int dones, busy_low, rises, bad_vec, guard;
        bit prev_busy;
        yv = golden();
        dones = 0; busy_low = 0; rises = 0; bad_vec = 0;
        prev_busy = bus.busy;
        bus.start = 1'b1;
        for (int k = 0; k < 120; k++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
            if (!bus.busy) begin
                busy_low++;
                if (bus.vec_o !== 4'd0) bad_vec++;
            end
            if (bus.busy && !prev_busy) rises++;
            prev_busy = bus.busy;
        end
        bus.start = 1'b0;
        vectors++;
        if (dones != 2) begin
            miscompares++;
            $display("FAIL b2b_dones: got %0d want 2", dones);
        end
        vectors++;
        if (rises != 3 || busy_low != 2) begin
            miscompares++;
            $display("FAIL b2b_accepts: got rises=%0d idle=%0d want 3 2", rises, busy_low);
        end
        vectors++;
        if (bad_vec != 0) begin
            miscompares++;
            $display("FAIL b2b_vec_idle: got %0d nonzero idle samples want 0", bad_vec);
        end
        guard = 0;
        while (bus.busy && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        yv = golden();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        guard = 0;
        while (bus.vec_o !== 4'd5 && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        vectors++;
        if (bus.vec_o !== 4'd5) begin
            miscompares++;
            $display("FAIL midrst_reach: vec=%h want 5", bus.vec_o);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.vec_o, bus.busy, bus.done, bus.truth_table, bus.mismatch_cnt, bus.pass, bus.xz_seen} !== '0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got vec=%h busy=%b tt=%h mc=%0d want all 0",
                     bus.vec_o, bus.busy, bus.truth_table, bus.mismatch_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        guard = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (bus.busy || bus.done || bus.vec_o !== 4'd0) guard++;
        end
        vectors++;
        if (guard != 0) begin
            miscompares++;
            $display("FAIL midrst_idle: got %0d active cycles want 0", guard);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_nominal();
        test_stuck0();
        test_z_at_12();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_nominal();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
